pong_frame_engine: RTL and testbench

Parametrised two-paddle game engine for the 1024x768 VGA path. It sits between the sync generator and the colour outputs: it takes pixel coordinates and a per-frame tick, and keeps ball, paddle, score and game state on a frame-rate state machine. Each cycle it produces the registered 24-bit colour for the current pixel. It adds a left paddle, scoring, a serve delay, a pause control and a one-player mode with an automatic right paddle.

---
 rtl/pong_frame_engine_if.sv | 32 +++
 rtl/pong_frame_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_pong_frame_engine.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_frame_engine_if.sv
// Pixel/control/status bundle between the sync generator side and the pong engine.
// master drives coordinates and player controls; slave (the engine) returns colour and game status.
interface pong_frame_engine_if #(
  parameter int SCORE_W = 4
) ();
  logic [10:0]        xPixel;
  logic [10:0]        yPixel;
  logic               frameTick;
  logic               leftUp;
  logic               leftDown;
  logic               rightUp;
  logic               rightDown;
  logic               twoPlayer;
  logic               pause;
  logic               startBtn;
  logic [23:0]        rgbColor;
  logic [SCORE_W-1:0] scoreLeft;
  logic [SCORE_W-1:0] scoreRight;
  logic [1:0]         gameState;

  modport master (
    output xPixel, yPixel, frameTick, leftUp, leftDown, rightUp, rightDown,
           twoPlayer, pause, startBtn,
    input  rgbColor, scoreLeft, scoreRight, gameState
  );

  modport slave (
    input  xPixel, yPixel, frameTick, leftUp, leftDown, rightUp, rightDown,
           twoPlayer, pause, startBtn,
    output rgbColor, scoreLeft, scoreRight, gameState
  );
endinterface

// File: rtl/pong_frame_engine.sv
// Two-paddle pong engine: frame-rate game FSM (ball, paddles, scores) plus a registered
// per-pixel colour generator for the 1024x768 visible area.
//
//   state    | meaning
//   SERVE    | ball held centred, serve counter runs, paddles move
//   PLAY     | ball and paddles move, bounces and misses evaluated
//   POINT    | one tick: re-centre ball, aim at conceding side, check for win
//   GAMEOVER | everything frozen until startBtn on a tick
module pong_frame_engine #(
  parameter int H_VISIBLE    = 1024,
  parameter int V_VISIBLE    = 768,
  parameter int BORDER       = 16,
  parameter int PADDLE_W     = 16,
  parameter int PADDLE_H     = 96,
  parameter int PADDLE_GAP   = 16,
  parameter int BALL_SIZE    = 16,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_STEP    = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 4
) (
  input  logic                 pixelClock,
  input  logic                 resetN,
  pong_frame_engine_if.slave   game_if
);

  localparam int SRV_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  typedef logic [11:0] coord_t;
  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam coord_t LX      = coord_t'(BORDER + PADDLE_GAP);
  localparam coord_t RX      = coord_t'(H_VISIBLE - BORDER - PADDLE_GAP - PADDLE_W);
  localparam coord_t PW      = coord_t'(PADDLE_W);
  localparam coord_t PH      = coord_t'(PADDLE_H);
  localparam coord_t BS      = coord_t'(BALL_SIZE);
  localparam coord_t PSTEP   = coord_t'(PADDLE_STEP);
  localparam coord_t BSTEP   = coord_t'(BALL_STEP);
  localparam coord_t PH_HALF = coord_t'(PADDLE_H / 2);
  localparam coord_t BS_HALF = coord_t'(BALL_SIZE / 2);
  localparam coord_t BRD     = coord_t'(BORDER);
  localparam coord_t X_BRD   = coord_t'(H_VISIBLE - BORDER);
  localparam coord_t Y_BRD   = coord_t'(V_VISIBLE - BORDER);
  localparam coord_t L_HIT   = LX + PW;
  localparam coord_t R_HIT   = RX - BS;
  localparam coord_t R_MISS  = coord_t'(H_VISIBLE - BORDER - BALL_SIZE);
  localparam coord_t BY_MAX  = coord_t'(V_VISIBLE - BORDER - BALL_SIZE);
  localparam coord_t PY_MAX  = coord_t'(V_VISIBLE - BORDER - PADDLE_H);
  localparam coord_t BX0     = coord_t'((H_VISIBLE - BALL_SIZE) / 2);
  localparam coord_t BY0     = coord_t'((V_VISIBLE - BALL_SIZE) / 2);
  localparam coord_t PY0     = coord_t'((V_VISIBLE - PADDLE_H) / 2);

  localparam logic [SRV_W-1:0]   SRV_LAST = SRV_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  localparam logic [23:0] C_BALL   = 24'hf0f0f0;
  localparam logic [23:0] C_PADDLE = 24'hffffff;
  localparam logic [23:0] C_BORDER = 24'h00ffff;
  localparam logic [23:0] C_BG     = 24'h000000;

  state_t             state_q, state_d;
  coord_t             ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic               ball_dx_q, ball_dx_d, ball_dy_q, ball_dy_d;
  coord_t             lpad_y_q, lpad_y_d, rpad_y_q, rpad_y_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [SRV_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic               left_scored_q, left_scored_d;
  logic [23:0]        rgb_q, rgb_d;

  coord_t nx, ny, px, py;
  logic   l_ovl, r_ovl, auto_up, auto_dn, advance;
  logic   in_ball, in_lpad, in_rpad, in_border;

  function automatic coord_t pad_move(input coord_t y, input logic up, input logic dn);
    coord_t r;
    r = y;
    if (up && !dn)      r = (y < BRD + PSTEP) ? BRD : y - PSTEP;
    else if (dn && !up) r = (y + PSTEP > PY_MAX) ? PY_MAX : y + PSTEP;
    return r;
  endfunction

  assign advance = game_if.frameTick && !game_if.pause;
  assign nx      = ball_dx_q ? ball_x_q + BSTEP : ball_x_q - BSTEP;
  assign ny      = ball_dy_q ? ball_y_q + BSTEP : ball_y_q - BSTEP;
  assign l_ovl   = (ball_y_q + BS > lpad_y_q) && (ball_y_q < lpad_y_q + PH);
  assign r_ovl   = (ball_y_q + BS > rpad_y_q) && (ball_y_q < rpad_y_q + PH);
  assign auto_up = (ball_y_q + BS_HALF + PSTEP) < (rpad_y_q + PH_HALF);
  assign auto_dn = (rpad_y_q + PH_HALF + PSTEP) < (ball_y_q + BS_HALF);

  assign px        = {1'b0, game_if.xPixel};
  assign py        = {1'b0, game_if.yPixel};
  assign in_ball   = (px >= ball_x_q) && (px < ball_x_q + BS) && (py >= ball_y_q) && (py < ball_y_q + BS);
  assign in_lpad   = (px >= LX) && (px < LX + PW) && (py >= lpad_y_q) && (py < lpad_y_q + PH);
  assign in_rpad   = (px >= RX) && (px < RX + PW) && (py >= rpad_y_q) && (py < rpad_y_q + PH);
  assign in_border = (px < BRD) || (px >= X_BRD) || (py < BRD) || (py >= Y_BRD);

  always_comb begin
    state_d       = state_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    ball_dx_d     = ball_dx_q;
    ball_dy_d     = ball_dy_q;
    lpad_y_d      = lpad_y_q;
    rpad_y_d      = rpad_y_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    serve_cnt_d   = serve_cnt_q;
    left_scored_d = left_scored_q;

    if (in_ball)        rgb_d = C_BALL;
    else if (in_lpad || in_rpad) rgb_d = C_PADDLE;
    else if (in_border) rgb_d = C_BORDER;
    else                rgb_d = C_BG;

    if (advance) begin
      if (state_q == ST_SERVE || state_q == ST_PLAY) begin
        lpad_y_d = pad_move(lpad_y_q, game_if.leftUp, game_if.leftDown);
        rpad_y_d = game_if.twoPlayer ? pad_move(rpad_y_q, game_if.rightUp, game_if.rightDown)
                                     : pad_move(rpad_y_q, auto_up, auto_dn);
      end

      unique case (state_q)
        ST_SERVE: begin
          if (serve_cnt_q == SRV_LAST) begin
            serve_cnt_d = '0;
            state_d     = ST_PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + SRV_W'(1);
          end
        end

        ST_PLAY: begin
          if (ny < BRD) begin
            ball_y_d  = BRD;
            ball_dy_d = ~ball_dy_q;
          end else if (ny > BY_MAX) begin
            ball_y_d  = BY_MAX;
            ball_dy_d = ~ball_dy_q;
          end else begin
            ball_y_d  = ny;
          end

          if (!ball_dx_q) begin
            if (nx <= L_HIT && ball_x_q >= L_HIT && l_ovl) begin
              ball_x_d  = L_HIT;
              ball_dx_d = 1'b1;
            end else if (nx <= BRD) begin
              score_r_d     = score_r_q + SCORE_W'(1);
              left_scored_d = 1'b0;
              state_d       = ST_POINT;
            end else begin
              ball_x_d = nx;
            end
          end else begin
            if (nx >= R_HIT && ball_x_q <= R_HIT && r_ovl) begin
              ball_x_d  = R_HIT;
              ball_dx_d = 1'b0;
            end else if (nx >= R_MISS) begin
              score_l_d     = score_l_q + SCORE_W'(1);
              left_scored_d = 1'b1;
              state_d       = ST_POINT;
            end else begin
              ball_x_d = nx;
            end
          end
        end

        ST_POINT: begin
          ball_x_d    = BX0;
          ball_y_d    = BY0;
          serve_cnt_d = '0;
          // serve toward whoever conceded: a left score means the right side missed
          ball_dx_d   = left_scored_q;
          state_d     = ((left_scored_q ? score_l_q : score_r_q) == WIN) ? ST_OVER : ST_SERVE;
        end

        ST_OVER: begin
          if (game_if.startBtn) begin
            score_l_d   = '0;
            score_r_d   = '0;
            serve_cnt_d = '0;
            ball_dx_d   = 1'b1;
            ball_dy_d   = 1'b1;
            state_d     = ST_SERVE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_SERVE;
      ball_x_q      <= BX0;
      ball_y_q      <= BY0;
      ball_dx_q     <= 1'b1;
      ball_dy_q     <= 1'b1;
      lpad_y_q      <= PY0;
      rpad_y_q      <= PY0;
      score_l_q     <= '0;
      score_r_q     <= '0;
      serve_cnt_q   <= '0;
      left_scored_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      ball_dx_q     <= ball_dx_d;
      ball_dy_q     <= ball_dy_d;
      lpad_y_q      <= lpad_y_d;
      rpad_y_q      <= rpad_y_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      serve_cnt_q   <= serve_cnt_d;
      left_scored_q <= left_scored_d;
      rgb_q         <= rgb_d;
    end
  end

  assign game_if.rgbColor   = rgb_q;
  assign game_if.scoreLeft  = score_l_q;
  assign game_if.scoreRight = score_r_q;
  assign game_if.gameState  = state_q;

endmodule

// File: tb/tb_pong_frame_engine.sv
// Directed bench for pong_frame_engine: ball/paddle positions are observed through the
// registered pixel colour, game progress through the score and state outputs.
module tb_pong_frame_engine;

  localparam logic [23:0] BALL = 24'hf0f0f0;
  localparam logic [23:0] PAD  = 24'hffffff;
  localparam logic [23:0] BRD  = 24'h00ffff;
  localparam logic [23:0] BG   = 24'h000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pong_frame_engine_if #(.SCORE_W(4)) gif ();

  pong_frame_engine dut (
    .pixelClock (clk),
    .resetN     (rst_n),
    .game_if    (gif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      gif.frameTick = 1'b1;
      @(negedge clk);
      gif.frameTick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp);
    gif.xPixel = 11'(x);
    gif.yPixel = 11'(y);
    @(negedge clk);
    chk(tag, 32'(gif.rgbColor), 32'(exp));
  endtask

  task automatic chk_status(input string tag, input int st, input int sl, input int sr);
    chk({tag, "_state"}, 32'(gif.gameState), st);
    chk({tag, "_scoreL"}, 32'(gif.scoreLeft), sl);
    chk({tag, "_scoreR"}, 32'(gif.scoreRight), sr);
  endtask

  task automatic do_reset(input logic two_player);
    rst_n          = 1'b0;
    gif.frameTick  = 1'b0;
    gif.leftUp     = 1'b0;
    gif.leftDown   = 1'b0;
    gif.rightUp    = 1'b0;
    gif.rightDown  = 1'b0;
    gif.pause      = 1'b0;
    gif.startBtn   = 1'b0;
    gif.twoPlayer  = two_player;
    gif.xPixel     = 11'd0;
    gif.yPixel     = 11'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // ---- reset values and static picture ----
    gif.xPixel = 11'd0;
    gif.yPixel = 11'd0;
    gif.frameTick = 1'b0;
    gif.leftUp = 1'b0; gif.leftDown = 1'b0;
    gif.rightUp = 1'b0; gif.rightDown = 1'b0;
    gif.twoPlayer = 1'b0; gif.pause = 1'b0; gif.startBtn = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", 32'(gif.rgbColor), 32'(BG));
    chk_status("rst", 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    tick(3);
    chk_status("idle3", 0, 0, 0);
    pix("ball_tl", 504, 376, BALL);
    pix("ball_br", 519, 391, BALL);
    pix("ball_right_out", 520, 391, BG);
    pix("ball_left_out", 503, 376, BG);
    pix("ball_top_out", 504, 375, BG);
    pix("lpad_tl", 32, 336, PAD);
    pix("lpad_bot", 32, 431, PAD);
    pix("lpad_below", 32, 432, BG);
    pix("lpad_xedge", 48, 336, BG);
    pix("rpad_tl", 976, 336, PAD);
    pix("rpad_right_out", 992, 400, BG);
    pix("brd_origin", 0, 0, BRD);
    pix("brd_left", 15, 400, BRD);
    pix("brd_left_in", 16, 400, BG);
    pix("brd_right", 1008, 400, BRD);
    pix("brd_right_in", 1007, 400, BG);
    pix("brd_bottom", 500, 752, BRD);
    pix("brd_bottom_in", 500, 751, BG);
    // latency: colour follows the coordinates only after the clock edge
    pix("lat_pre", 100, 100, BG);
    gif.xPixel = 11'd32;
    gif.yPixel = 11'd336;
    #1 chk("lat_hold", 32'(gif.rgbColor), 32'(BG));
    @(negedge clk);
    chk("lat_paddle", 32'(gif.rgbColor), 32'(PAD));

    // ---- serve timing with pause, automatic right paddle ignoring its buttons ----
    do_reset(1'b0);
    gif.rightUp = 1'b1;
    tick(30);
    gif.pause = 1'b1;
    tick(5);
    gif.pause = 1'b0;
    tick(29);
    chk_status("serve59", 0, 0, 0);
    tick(1);
    chk_status("serve60", 1, 0, 0);
    pix("serve60_ball", 504, 376, BALL);
    pix("auto_rpad", 976, 336, PAD);
    pix("auto_rpad_above", 976, 335, BG);
    tick(1);
    pix("play1_ball", 506, 378, BALL);
    pix("play1_left_out", 505, 378, BG);
    pix("play1_top_out", 506, 377, BG);
    gif.pause = 1'b1;
    tick(10);
    gif.pause = 1'b0;
    chk_status("paused", 1, 0, 0);
    pix("paused_ball", 521, 393, BALL);
    pix("paused_ball_out", 522, 393, BG);
    tick(1);
    pix("play2_ball", 508, 380, BALL);
    pix("play2_left_out", 507, 380, BG);
    gif.rightUp = 1'b0;

    // ---- left paddle clamping and up+down hold ----
    do_reset(1'b0);
    gif.leftUp = 1'b1;
    tick(100);
    pix("lup_top", 32, 16, PAD);
    pix("lup_bot", 32, 111, PAD);
    pix("lup_below", 32, 112, BG);
    pix("lup_border", 32, 15, BRD);
    gif.leftDown = 1'b1;
    tick(5);
    pix("lboth_top", 32, 16, PAD);
    pix("lboth_below", 32, 112, BG);
    gif.leftUp = 1'b0;
    tick(1);
    pix("ldn1_old_top", 32, 16, BG);
    pix("ldn1_top", 32, 20, PAD);
    tick(170);
    pix("ldn_top", 32, 656, PAD);
    pix("ldn_bot", 32, 751, PAD);
    pix("ldn_above", 32, 655, BG);
    gif.leftDown = 1'b0;

    // ---- left paddle hit: paddle raised to y=300 during serve ----
    do_reset(1'b0);
    gif.leftUp = 1'b1;
    tick(9);
    gif.leftUp = 1'b0;
    tick(51);
    chk("hit_play", 32'(gif.gameState), 1);
    tick(683);
    pix("hit_k683", 50, 298, BALL);
    pix("hit_k683_out", 49, 298, BG);
    tick(1);
    pix("hit_land", 48, 300, BALL);
    pix("hit_paddle_beside", 47, 300, PAD);
    tick(1);
    pix("hit_rebound", 50, 302, BALL);
    pix("hit_rebound_lout", 49, 302, BG);
    pix("hit_rebound_r", 65, 302, BALL);
    pix("hit_rebound_rout", 66, 302, BG);
    chk_status("hit", 1, 0, 0);

    // ---- left paddle miss: right player scores ----
    do_reset(1'b0);
    tick(60);
    tick(683);
    pix("miss_k683", 50, 298, BALL);
    tick(1);
    pix("miss_k684", 48, 300, BALL);
    tick(1);
    pix("miss_k685", 46, 302, BALL);
    tick(14);
    pix("ball_over_paddle", 33, 340, BALL);
    pix("paddle_beside_ball", 34, 340, PAD);
    pix("miss_k699", 18, 330, BALL);
    pix("miss_k699_out", 17, 330, BG);
    chk_status("miss_k699", 1, 0, 0);
    tick(1);
    chk_status("point", 2, 0, 1);
    tick(1);
    chk_status("after_point", 0, 0, 1);
    pix("recentred", 504, 376, BALL);
    tick(59);
    chk("reserve59", 32'(gif.gameState), 0);
    tick(1);
    chk("reserve60", 32'(gif.gameState), 1);
    tick(1);
    pix("serve_left", 502, 378, BALL);
    pix("serve_left_rout", 518, 378, BG);
    pix("serve_left_lout", 501, 378, BG);

    // ---- left player runs to WIN_SCORE, then restart ----
    do_reset(1'b1);
    for (int p = 1; p <= 8; p++) begin
      tick(304);
      chk("pt_scoreL", 32'(gif.scoreLeft), p);
      chk("pt_state", 32'(gif.gameState), 2);
      tick(1);
      chk("pt_serve", 32'(gif.gameState), 0);
    end
    chk("pt_scoreR", 32'(gif.scoreRight), 0);
    tick(304);
    chk_status("win_point", 2, 9, 0);
    tick(1);
    chk_status("gameover", 3, 9, 0);
    tick(5);
    chk_status("gameover_hold", 3, 9, 0);
    pix("gameover_ball", 504, 376, BALL);
    gif.startBtn = 1'b1;
    repeat (2) @(negedge clk);
    chk_status("start_no_tick", 3, 9, 0);
    gif.pause = 1'b1;
    tick(1);
    chk_status("start_paused", 3, 9, 0);
    gif.pause = 1'b0;
    tick(1);
    gif.startBtn = 1'b0;
    chk_status("restart", 0, 0, 0);
    tick(60);
    chk("restart_play", 32'(gif.gameState), 1);
    tick(1);
    pix("restart_dir", 506, 378, BALL);

    // ---- asynchronous reset in the middle of POINT ----
    do_reset(1'b1);
    tick(304);
    chk_status("pre_async", 2, 1, 0);
    pix("pre_async_rgb", 0, 0, BRD);
    #2 rst_n = 1'b0;
    #1;
    chk_status("async", 0, 0, 0);
    chk("async_rgb", 32'(gif.rgbColor), 32'(BG));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
